// File: rtl/div_multicycle.sv
// div_multicycle: multi-cycle RV32M/RV64M DIV/DIVU/REM/REMU unit with fast path and flush.
module div_multicycle #(
  parameter int XLEN = 32,
  parameter int REG_ADDR_W = 5,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [XLEN-1:0]       dividend_i,
  input  logic [XLEN-1:0]       divisor_i,
  input  logic [REG_ADDR_W-1:0] reg_waddr_i,
  input  logic                  flush_i,
  output logic [XLEN-1:0]       result_o,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic [REG_ADDR_W-1:0] reg_waddr_o
);
  localparam int N = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam int PW = XLEN + BITS_PER_CYCLE;
  localparam logic [CW-1:0] LAST = CW'(N);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] rem, rem_n, sh;
  logic [PW:0] df;
  logic ge;
  logic [XLEN-1:0] quo, quo_n, dvs;
  logic is_rem, neg_q, neg_r;
  logic sgn, a_neg, b_neg, dz, ovf, fast;
  logic [XLEN-1:0] abs_a, abs_b, fast_res, fix_q, fix_r;
  always_comb begin
    sgn = ~op_i[0];
    a_neg = sgn & dividend_i[XLEN-1];
    b_neg = sgn & divisor_i[XLEN-1];
    abs_a = a_neg ? -dividend_i : dividend_i;
    abs_b = b_neg ? -divisor_i : divisor_i;
    dz = divisor_i == '0;
    ovf = sgn & (dividend_i == MIN) & (&divisor_i);
    fast = ~op_i[2] | dz | ovf;
    fast_res = ~op_i[2] ? '0 : dz ? (op_i[1] ? dividend_i : '1) : (op_i[1] ? '0 : dividend_i);
    fix_q = neg_q ? -quo : quo;
    fix_r = neg_r ? -rem[XLEN-1:0] : rem[XLEN-1:0];
  end
  // restoring steps chained combinationally; quo shifts dividend bits out and quotient bits in
  always_comb begin
    rem_n = rem;
    quo_n = quo;
    sh = '0;
    df = '0;
    ge = 1'b0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      sh = {rem_n[PW-2:0], quo_n[XLEN-1]};
      df = {1'b0, sh} - {{(PW+1-XLEN){1'b0}}, dvs};
      ge = rem_n[PW-1] | ~df[PW];
      rem_n = ge ? df[PW-1:0] : sh;
      quo_n = {quo_n[XLEN-2:0], ge};
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      is_rem <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      result_o <= '0;
      ready_o <= 1'b0;
      busy_o <= 1'b0;
      reg_waddr_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          ready_o <= 1'b0;
          if (start_i && !flush_i) begin
            reg_waddr_o <= reg_waddr_i;
            is_rem <= op_i[1];
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            quo <= abs_a;
            dvs <= abs_b;
            rem <= '0;
            cnt <= '0;
            state <= fast ? DONE : CALC;
            busy_o <= ~fast;
            ready_o <= fast;
            if (fast) result_o <= fast_res;
          end
        end
        CALC: begin
          if (flush_i) begin
            state <= IDLE;
            busy_o <= 1'b0;
          end else if (cnt == LAST) begin
            state <= DONE;
            busy_o <= 1'b0;
            ready_o <= 1'b1;
            result_o <= is_rem ? fix_r : fix_q;
          end else begin
            rem <= rem_n;
            quo <= quo_n;
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          ready_o <= 1'b0;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
